// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, IR field
// positions, sequencer state encoding and opcode classification helpers.
package cpu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Wide ops produce a HI/LO result pair and need the extra T6 transfer.
  function automatic logic is_wide(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Binary register index to one-hot general register strobe, gated by an enable.
module reg_onehot_decoder #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4
) (
  input  logic                en,
  input  logic [REG_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for one register-register ALU instruction on the single-bus
// datapath: fetch, decode of the latched IR, execute and write-back.
module alu_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic                mem_rdy,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                Zhiout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  import cpu_pkg::*;

  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t state, next_state;

  logic [4:0]       op_q;
  logic [REG_W-1:0] ra_q, rb_q, rc_q;

  logic             rin_en, rout_en;
  logic [REG_W-1:0] rout_sel;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= S_IDLE;
    else        state <= next_state;
  end

  // IR fields are latched on the way into T3 so execute strobes never depend
  // combinationally on the ir input.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state == S_T2) begin
      op_q <= ir[OPC_LSB +: 5];
      ra_q <= ir[RA_LSB +: REG_W];
      rb_q <= ir[RB_LSB +: REG_W];
      rc_q <= ir[RC_LSB +: REG_W];
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)                               illegal <= 1'b0;
    else if (state == S_IDLE && start)        illegal <= 1'b0;
    else if (state == S_T3 && !is_legal(op_q)) illegal <= 1'b1;
  end

  always_comb begin
    next_state = state;
    PCout      = 1'b0;
    Zhiout     = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    alu_op     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_sel   = rb_q;

    case (state)
      S_IDLE: begin
        if (start) next_state = S_T0;
      end
      S_T0: begin
        busy       = 1'b1;
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) next_state = S_T2;
      end
      S_T2: begin
        busy       = 1'b1;
        MDRout     = 1'b1;
        IRin       = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (!is_legal(op_q)) begin
          next_state = S_DONE;
        end else if (is_unary(op_q)) begin
          rout_en    = 1'b1;
          alu_op     = OP_W'(op_q);
          Zin        = 1'b1;
          next_state = S_T4;
        end else begin
          rout_en    = 1'b1;
          Yin        = 1'b1;
          next_state = S_T4;
        end
      end
      S_T4: begin
        busy = 1'b1;
        if (is_unary(op_q)) begin
          Zlowout    = 1'b1;
          rin_en     = 1'b1;
          next_state = S_DONE;
        end else begin
          rout_en    = 1'b1;
          rout_sel   = rc_q;
          alu_op     = OP_W'(op_q);
          Zin        = 1'b1;
          next_state = S_T5;
        end
      end
      S_T5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        if (is_wide(op_q)) begin
          LOin       = 1'b1;
          next_state = S_T6;
        end else begin
          rin_en     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_T6: begin
        busy       = 1'b1;
        Zhiout     = 1'b1;
        HIin       = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_reg_in_dec (
    .en     (rin_en),
    .sel    (ra_q),
    .onehot (reg_in)
  );

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_reg_out_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (reg_out)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed test-plan cases plus
// randomized instructions compared cycle by cycle against an expected strobe trace.
module tb_alu_op_sequencer;

  localparam int NUM_REGS = 16;
  localparam int OP_W     = 5;

  localparam logic [15:0] M_PCOUT  = 16'h8000;
  localparam logic [15:0] M_ZHI    = 16'h4000;
  localparam logic [15:0] M_ZLO    = 16'h2000;
  localparam logic [15:0] M_MDROUT = 16'h1000;
  localparam logic [15:0] M_MARIN  = 16'h0800;
  localparam logic [15:0] M_ZIN    = 16'h0400;
  localparam logic [15:0] M_PCIN   = 16'h0200;
  localparam logic [15:0] M_MDRIN  = 16'h0100;
  localparam logic [15:0] M_IRIN   = 16'h0080;
  localparam logic [15:0] M_YIN    = 16'h0040;
  localparam logic [15:0] M_HIIN   = 16'h0020;
  localparam logic [15:0] M_LOIN   = 16'h0010;
  localparam logic [15:0] M_INCPC  = 16'h0008;
  localparam logic [15:0] M_READ   = 16'h0004;
  localparam logic [15:0] M_BUSY   = 16'h0002;
  localparam logic [15:0] M_DONE   = 16'h0001;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        ill;
  } rec_t;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  logic start = 1'b0;
  logic mem_rdy = 1'b0;
  logic [31:0] ir = '0;

  logic PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read, busy, done, illegal;
  logic [NUM_REGS-1:0] reg_in, reg_out;
  logic [OP_W-1:0] alu_op;

  int errors = 0;
  int checks = 0;
  logic ill_model = 1'b0;
  rec_t exp_q[$];

  logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  alu_op_sequencer #(.NUM_REGS(NUM_REGS), .OP_W(OP_W)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  function automatic rec_t observe();
    rec_t r;
    r.ctrl = {PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin,
              IRin, Yin, HIin, LOin, IncPC, Read, busy, done};
    r.rin  = reg_in;
    r.rout = reg_out;
    r.alu  = alu_op;
    r.ill  = illegal;
    return r;
  endfunction

  function automatic rec_t mk(input logic [15:0] c, input logic [15:0] ri,
                              input logic [15:0] ro, input logic [4:0] a, input logic il);
    rec_t r;
    r.ctrl = c;
    r.rin  = ri;
    r.rout = ro;
    r.alu  = a;
    r.ill  = il;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected per-cycle outputs from T0 through DONE, derived from the opcode class.
  task automatic buildTrace(input logic [31:0] instr, input int stall);
    logic [4:0] opc = instr[31:27];
    int ra = int'(instr[26:23]);
    int rb = int'(instr[22:19]);
    int rc = int'(instr[18:15]);
    bit legal = (opc >= 5'd3 && opc <= 5'd11) || (opc >= 5'd15 && opc <= 5'd18);
    bit unary = (opc == 5'd17) || (opc == 5'd18);
    bit wide  = (opc == 5'd15) || (opc == 5'd16);
    exp_q.delete();
    exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY, 0, 0, 0, 0));
    for (int i = 0; i <= stall; i++)
      exp_q.push_back(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN | M_BUSY, 0, 0, 0, 0));
    exp_q.push_back(mk(M_MDROUT | M_IRIN | M_BUSY, 0, 0, 0, 0));
    if (!legal) begin
      exp_q.push_back(mk(M_BUSY, 0, 0, 0, 0));
    end else if (unary) begin
      exp_q.push_back(mk(M_ZIN | M_BUSY, 0, 16'(1 << rb), opc, 0));
      exp_q.push_back(mk(M_ZLO | M_BUSY, 16'(1 << ra), 0, 0, 0));
    end else begin
      exp_q.push_back(mk(M_YIN | M_BUSY, 0, 16'(1 << rb), 0, 0));
      exp_q.push_back(mk(M_ZIN | M_BUSY, 0, 16'(1 << rc), opc, 0));
      if (wide) begin
        exp_q.push_back(mk(M_ZLO | M_LOIN | M_BUSY, 0, 0, 0, 0));
        exp_q.push_back(mk(M_ZHI | M_HIIN | M_BUSY, 0, 0, 0, 0));
      end else begin
        exp_q.push_back(mk(M_ZLO | M_BUSY, 16'(1 << ra), 0, 0, 0));
      end
    end
    exp_q.push_back(mk(M_DONE, 0, 0, 0, !legal));
  endtask

  // Entered and left at a falling edge while the sequencer is idle.
  task automatic applyStimulus(input logic [31:0] instr, input int stall,
                               input bit inject, input int abort_at);
    int done_cycle = -1;
    rec_t got;
    checkOutput("idle", 64'(observe()), 64'(mk(0, 0, 0, 0, ill_model)));
    buildTrace(instr, stall);
    start   = 1'b1;
    ir      = instr;
    mem_rdy = 1'($urandom_range(0, 1));
    @(negedge Clock);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = observe();
      checkOutput($sformatf("ir%h_cyc%0d", instr, i), 64'(got), 64'(exp_q[i]));
      if (got.ctrl[0] && done_cycle < 0) done_cycle = i + 1;
      if (i == abort_at) begin
        #2 Clear = 1'b0;
        #1 checkOutput("reset_async", 64'(observe()), 64'(0));
        @(negedge Clock);
        checkOutput("reset_held", 64'(observe()), 64'(0));
        Clear     = 1'b1;
        start     = 1'b0;
        ill_model = 1'b0;
        @(negedge Clock);
        return;
      end
      if (i >= 1 && i <= stall)  mem_rdy = 1'b0;
      else if (i == stall + 1)   mem_rdy = 1'b1;
      else                       mem_rdy = 1'($urandom_range(0, 1));
      if (i > stall + 2) ir = $urandom;
      start = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clock);
    end
    checkOutput($sformatf("latency_ir%h", instr), 64'(done_cycle), 64'(exp_q.size()));
    ill_model = exp_q[exp_q.size() - 1].ill;
    start = 1'b0;
  endtask

  initial begin
    logic [4:0]  opc;
    logic [31:0] instr;
    $display("[TB] starting alu_op_sequencer bench");
    repeat (2) @(negedge Clock);
    checkOutput("reset_initial", 64'(observe()), 64'(0));
    Clear = 1'b1;
    @(negedge Clock);

    applyStimulus(32'h92900000, 0, 1'b0, -1);
    applyStimulus(32'h18918000, 0, 1'b0, -1);
    applyStimulus(32'h78338000, 0, 1'b0, -1);
    applyStimulus(32'h92900000, 3, 1'b0, -1);
    applyStimulus(32'hF8000000, 0, 1'b1, -1);
    applyStimulus(32'h18918000, 1, 1'b0, -1);

    // illegal flag must also drop on an asynchronous reset while idle
    applyStimulus(32'hF8000000, 0, 1'b0, -1);
    #2 Clear = 1'b0;
    #1 checkOutput("reset_clears_illegal", 64'(illegal), 64'(0));
    ill_model = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);

    // reset in the middle of T4 of an ADD, then restart
    applyStimulus(32'h18918000, 0, 1'b0, 4);
    applyStimulus(32'h92900000, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) opc = 5'($urandom);
      else                           opc = legal_ops[$urandom_range(0, 12)];
      instr = {opc, 27'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        checkOutput("gap", 64'(observe()), 64'(mk(0, 0, 0, 0, ill_model)));
        @(negedge Clock);
      end
      applyStimulus(instr, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
